btb_update_scheduler: RTL and testbench

Sequences all writes into the branch predictor's BTB update port. Two branch-resolution sources post outcomes into a shared QUEUE_DEPTH-entry FIFO; the block drains one update per free cycle onto the BTB's single update port. On request, it runs a full-table invalidation walk. It sits between the branch functional units and the BTB (update_btb / update_pc / branch_outcome / branch_target side).

---
 rtl/btb_update_scheduler.sv | 259 +++++++++++++++++++++++++
 tb/tb_btb_update_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_scheduler.sv
// -----------------------------------------------------------------------------
// btb_update_scheduler
//
// Purpose:
//   Serialises every write into the BTB's single update port. Two branch
//   resolution sources post outcomes into a shared QUEUE_DEPTH-entry FIFO.
//   One entry drains per cycle in which the BTB port is free. On flush_req_i
//   the queue is dropped and a full-table invalidation walk writes
//   NUM_ENTRIES zeroed entries.
//
// Optional feature (macro BTB_UPD_COALESCE_EN):
//   An accepted update whose PC matches a live queued entry rewrites that
//   entry in place and does not take a new slot. The head entry being popped
//   this cycle is not a candidate. Without the macro no PC comparators exist.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   res{0,1}_valid_i                  source k presents an update
//   res{0,1}_pc_i/_taken_i/_target_i  update payload
//   res{0,1}_ready_o                  source k accepted this cycle if valid
//   flush_req_i                       request full BTB invalidation
//   btb_stall_i                       BTB update port busy this cycle
//   update_btb_o                      BTB write strobe
//   update_pc_o, branch_target_o      write address / target
//   branch_outcome_o                  write outcome
//   flush_busy_o                      high during the invalidation walk
//   flush_done_o                      one-cycle pulse after the last walk write
//   queue_count_o                     occupied FIFO entries
// -----------------------------------------------------------------------------
module btb_update_scheduler #(
  parameter int QUEUE_DEPTH = 4,
  parameter int NUM_ENTRIES = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               res0_valid_i,
  input  logic [31:0]                        res0_pc_i,
  input  logic                               res0_taken_i,
  input  logic [31:0]                        res0_target_i,
  output logic                               res0_ready_o,
  input  logic                               res1_valid_i,
  input  logic [31:0]                        res1_pc_i,
  input  logic                               res1_taken_i,
  input  logic [31:0]                        res1_target_i,
  output logic                               res1_ready_o,
  input  logic                               flush_req_i,
  input  logic                               btb_stall_i,
  output logic                               update_btb_o,
  output logic [31:0]                        update_pc_o,
  output logic                               branch_outcome_o,
  output logic [31:0]                        branch_target_o,
  output logic                               flush_busy_o,
  output logic                               flush_done_o,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count_o
);

  localparam int PTR_W    = $clog2(QUEUE_DEPTH);
  localparam int CNT_W    = $clog2(QUEUE_DEPTH + 1);
  localparam int IDX_BITS = $clog2(NUM_ENTRIES);

  localparam logic [CNT_W-1:0]    DEPTH_C    = CNT_W'(QUEUE_DEPTH);
  localparam logic [IDX_BITS-1:0] LAST_IDX_C = IDX_BITS'(NUM_ENTRIES - 1);

  typedef enum logic {ST_IDLE, ST_FLUSH} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic                 rr_q, rr_d;
  logic [IDX_BITS-1:0]  walk_idx_q, walk_idx_d;
  logic                 flush_done_q, flush_done_d;

  // FIFO storage; no reset needed because an entry is only read while live.
  logic [31:0]          pc_mem     [QUEUE_DEPTH];
  logic                 taken_mem  [QUEUE_DEPTH];
  logic [31:0]          target_mem [QUEUE_DEPTH];

  logic [CNT_W-1:0]       space;
  logic                   idle_open;
  logic                   rdy0, rdy1;
  logic                   acc0, acc1;
  logic                   deq;
  logic                   wr_flush;
  logic                   new0, new1;
  logic                   same_pc;
  logic [QUEUE_DEPTH-1:0] hit0_vec, hit1_vec;
  logic [QUEUE_DEPTH-1:0] wr0_vec, wr1_vec;
  logic [PTR_W-1:0]       slot0, slot1;

  // ---------------------------------------------------------------------------
  // Handshake and drain decisions (space uses the pre-dequeue count).
  // ---------------------------------------------------------------------------
  assign space     = DEPTH_C - count_q;
  assign idle_open = (state_q == ST_IDLE) && !flush_req_i;

  // With one free slot only the round-robin favoured source may enqueue.
  assign rdy0 = idle_open && ((space >= CNT_W'(2)) || ((space == CNT_W'(1)) && !rr_q));
  assign rdy1 = idle_open && ((space >= CNT_W'(2)) || ((space == CNT_W'(1)) &&  rr_q));

  assign acc0 = res0_valid_i && rdy0;
  assign acc1 = res1_valid_i && rdy1;

  assign deq      = idle_open && (count_q != '0) && !btb_stall_i;
  assign wr_flush = (state_q == ST_FLUSH) && !btb_stall_i;

  // ---------------------------------------------------------------------------
  // PC match against live queue entries (coalescing build only).
  // ---------------------------------------------------------------------------
`ifdef BTB_UPD_COALESCE_EN
  generate
    for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_match
      logic [PTR_W-1:0] offset;
      logic             live;
      // Distance from head decides whether slot gi holds a queued entry;
      // the head being popped this cycle is excluded from matching.
      assign offset       = PTR_W'(gi) - head_q;
      assign live         = (CNT_W'(offset) < count_q) && !(deq && (offset == '0));
      assign hit0_vec[gi] = live && (pc_mem[gi] == res0_pc_i);
      assign hit1_vec[gi] = live && (pc_mem[gi] == res1_pc_i);
    end
  endgenerate
  assign same_pc = (res0_pc_i == res1_pc_i);
`else
  assign hit0_vec = '0;
  assign hit1_vec = '0;
  assign same_pc  = 1'b0;
`endif

  // A source takes a new slot only when it did not merge. When both sources
  // carry the same PC, res1 lands wherever res0 went, so it never allocates.
  assign new0  = acc0 && !(|hit0_vec);
  assign new1  = acc1 && !(|hit1_vec) && !(acc0 && same_pc);
  assign slot0 = tail_q;
  assign slot1 = tail_q + PTR_W'(new0);

  generate
    for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_wsel
      assign wr0_vec[gi] = (acc0 && hit0_vec[gi]) ||
                           (new0 && (slot0 == PTR_W'(gi)));
      assign wr1_vec[gi] = (acc1 && hit1_vec[gi]) ||
                           (new1 && (slot1 == PTR_W'(gi))) ||
                           (acc1 && same_pc && new0 && (slot0 == PTR_W'(gi)));
    end
  endgenerate

  // res1 has priority on a shared slot so it lands after res0.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (wr1_vec[i]) begin
        pc_mem[i]     <= res1_pc_i;
        taken_mem[i]  <= res1_taken_i;
        target_mem[i] <= res1_target_i;
      end else if (wr0_vec[i]) begin
        pc_mem[i]     <= res0_pc_i;
        taken_mem[i]  <= res0_taken_i;
        target_mem[i] <= res0_target_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      rr_q         <= 1'b0;
      walk_idx_q   <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      rr_q         <= rr_d;
      walk_idx_q   <= walk_idx_d;
      flush_done_q <= flush_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (flush_req_i) state_d = ST_FLUSH;
      ST_FLUSH: if (wr_flush && (walk_idx_q == LAST_IDX_C)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Queue pointers, arbitration and walk index.
  always_comb begin
    count_d      = count_q;
    head_d       = head_q;
    tail_d       = tail_q;
    rr_d         = rr_q;
    walk_idx_d   = walk_idx_q;
    flush_done_d = 1'b0;
    if (state_q == ST_FLUSH) begin
      if (wr_flush) begin
        // Power-of-two table: the increment wraps to 0 after the last entry.
        walk_idx_d = walk_idx_q + 1'b1;
        if (walk_idx_q == LAST_IDX_C) flush_done_d = 1'b1;
      end
    end else if (flush_req_i) begin
      count_d    = '0;
      head_d     = tail_q;
      walk_idx_d = '0;
    end else begin
      if ((acc0 || acc1) && (space == CNT_W'(1))) rr_d = !rr_q;
      head_d  = head_q + PTR_W'(deq);
      tail_d  = tail_q + PTR_W'(new0) + PTR_W'(new1);
      count_d = count_q + CNT_W'(new0) + CNT_W'(new1) - CNT_W'(deq);
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    res0_ready_o     = 1'b0;
    res1_ready_o     = 1'b0;
    update_btb_o     = 1'b0;
    update_pc_o      = '0;
    branch_outcome_o = 1'b0;
    branch_target_o  = '0;
    flush_busy_o     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        res0_ready_o = rdy0;
        res1_ready_o = rdy1;
        if (deq) begin
          update_btb_o     = 1'b1;
          update_pc_o      = pc_mem[head_q];
          branch_outcome_o = taken_mem[head_q];
          branch_target_o  = target_mem[head_q];
        end
      end
      ST_FLUSH: begin
        flush_busy_o = 1'b1;
        if (wr_flush) begin
          update_btb_o = 1'b1;
          update_pc_o  = 32'({walk_idx_q, 2'b00});
        end
      end
      default: ;
    endcase
  end

  assign flush_done_o  = flush_done_q;
  assign queue_count_o = count_q;

endmodule

// File: tb/tb_btb_update_scheduler.sv
// -----------------------------------------------------------------------------
// tb_btb_update_scheduler
//
// Purpose: self-checking bench for btb_update_scheduler. A queue-based model
// of the update FIFO, arbitration and flush walk predicts every output each
// cycle; directed scenarios are followed by randomized traffic.
// Honours BTB_UPD_COALESCE_EN in its model when the macro is defined.
// -----------------------------------------------------------------------------
module tb_btb_update_scheduler;

  localparam int QUEUE_DEPTH = 4;
  localparam int NUM_ENTRIES = 16;
  localparam int CNT_W       = $clog2(QUEUE_DEPTH + 1);

  logic              clk;
  logic              rst;
  logic              res0_valid, res1_valid;
  logic [31:0]       res0_pc, res1_pc;
  logic              res0_taken, res1_taken;
  logic [31:0]       res0_target, res1_target;
  logic              res0_ready, res1_ready;
  logic              flush_req;
  logic              btb_stall;
  logic              update_btb;
  logic [31:0]       update_pc;
  logic              branch_outcome;
  logic [31:0]       branch_target;
  logic              flush_busy;
  logic              flush_done;
  logic [CNT_W-1:0]  queue_count;

  btb_update_scheduler #(
    .QUEUE_DEPTH (QUEUE_DEPTH),
    .NUM_ENTRIES (NUM_ENTRIES)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .res0_valid_i     (res0_valid),
    .res0_pc_i        (res0_pc),
    .res0_taken_i     (res0_taken),
    .res0_target_i    (res0_target),
    .res0_ready_o     (res0_ready),
    .res1_valid_i     (res1_valid),
    .res1_pc_i        (res1_pc),
    .res1_taken_i     (res1_taken),
    .res1_target_i    (res1_target),
    .res1_ready_o     (res1_ready),
    .flush_req_i      (flush_req),
    .btb_stall_i      (btb_stall),
    .update_btb_o     (update_btb),
    .update_pc_o      (update_pc),
    .branch_outcome_o (branch_outcome),
    .branch_target_o  (branch_target),
    .flush_busy_o     (flush_busy),
    .flush_done_o     (flush_done),
    .queue_count_o    (queue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  ent_t mq[$];
  bit   m_rr;
  bit   m_flush;
  int   m_walk;
  bit   m_done;

  int   n_cmp;
  int   n_err;
  int   flush_writes;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic void push(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    ent_t e;
`ifdef BTB_UPD_COALESCE_EN
    foreach (mq[i]) begin
      if (mq[i].pc == pc) begin
        mq[i].taken  = tk;
        mq[i].target = tg;
        return;
      end
    end
`endif
    e.pc     = pc;
    e.taken  = tk;
    e.target = tg;
    mq.push_back(e);
  endfunction

  // Called at posedge+1 with inputs already set: check at negedge, then
  // advance the model across the next rising edge.
  task automatic cycle();
    int   space;
    bit   e_r0, e_r1, e_upd, a0, a1;
    ent_t e_ent;
    e_ent.pc = '0; e_ent.taken = 1'b0; e_ent.target = '0;
    #4;
    space = QUEUE_DEPTH - mq.size();
    if (m_flush) begin
      e_r0  = 0;
      e_r1  = 0;
      e_upd = !btb_stall;
      e_ent.pc = 32'(m_walk * 4);
    end else begin
      e_r0  = !flush_req && (space >= 2 || (space == 1 && !m_rr));
      e_r1  = !flush_req && (space >= 2 || (space == 1 &&  m_rr));
      e_upd = !flush_req && (mq.size() > 0) && !btb_stall;
      if (mq.size() > 0) e_ent = mq[0];
    end
    check("res0_ready", 32'(res0_ready), 32'(e_r0));
    check("res1_ready", 32'(res1_ready), 32'(e_r1));
    check("update_btb", 32'(update_btb), 32'(e_upd));
    if (e_upd) begin
      check("update_pc", update_pc, e_ent.pc);
      check("branch_outcome", 32'(branch_outcome), 32'(e_ent.taken));
      check("branch_target", branch_target, e_ent.target);
      $display("update pc=%h outcome=%0d target=%h busy=%0d", update_pc, branch_outcome,
               branch_target, flush_busy);
    end
    check("flush_busy", 32'(flush_busy), 32'(m_flush));
    check("flush_done", 32'(flush_done), 32'(m_done));
    check("queue_count", 32'(queue_count), 32'(mq.size()));
    if (m_flush && update_btb) flush_writes++;
    a0 = res0_valid && e_r0;
    a1 = res1_valid && e_r1;

    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      m_rr = 0; m_flush = 0; m_walk = 0; m_done = 0;
    end else if (m_flush) begin
      m_done = 0;
      if (!btb_stall) begin
        if (m_walk == NUM_ENTRIES - 1) begin
          m_flush = 0; m_walk = 0; m_done = 1;
        end else begin
          m_walk++;
        end
      end
    end else begin
      m_done = 0;
      if (flush_req) begin
        mq.delete();
        m_flush = 1;
        m_walk  = 0;
      end else begin
        if (space == 1 && (a0 || a1)) m_rr = !m_rr;
        if (e_upd) void'(mq.pop_front());
        if (a0) push(res0_pc, res0_taken, res0_target);
        if (a1) push(res1_pc, res1_taken, res1_target);
      end
    end
  endtask

  task automatic idle_inputs();
    res0_valid = 0; res1_valid = 0; flush_req = 0; btb_stall = 0; rst = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    n_cmp = 0; n_err = 0; flush_writes = 0;
    m_rr = 0; m_flush = 0; m_walk = 0; m_done = 0;
    res0_pc = '0; res1_pc = '0; res0_taken = 0; res1_taken = 0;
    res0_target = '0; res1_target = '0;
    idle_inputs();
    rst = 1;
    @(posedge clk);
    #1;
    cycle();                       // reset values while reset held
    rst = 0;

    // Single update, 1-cycle latency
    res0_valid = 1; res0_pc = 32'h100; res0_taken = 1; res0_target = 32'h200;
    cycle();
    res0_valid = 0;
    repeat (2) cycle();

    // Fill with both sources under stall, then drain in order
    btb_stall = 1; res0_valid = 1; res1_valid = 1;
    for (int i = 0; i < 6; i++) begin
      res0_pc = 32'h1000 + 32'(i * 8); res0_taken = 1'(i); res0_target = 32'hA000 + 32'(i);
      res1_pc = 32'h1004 + 32'(i * 8); res1_taken = 1'(~i); res1_target = 32'hB000 + 32'(i);
      cycle();
    end
    res0_valid = 0; res1_valid = 0; btb_stall = 0;
    repeat (5) cycle();

    // Flush with 3 queued entries, no stalls
    btb_stall = 1; res0_valid = 1; res1_valid = 1;
    res0_pc = 32'h300; res1_pc = 32'h304;
    cycle();
    res1_valid = 0; res0_pc = 32'h308;
    cycle();
    res0_valid = 0; btb_stall = 0; flush_req = 1;
    flush_writes = 0;
    cycle();
    flush_req = 0;
    for (int k = 0; k < 100 && m_flush; k++) cycle();
    cycle();                       // flush_done pulse and readies back
    check("flush_write_count", 32'(flush_writes), 32'(NUM_ENTRIES));

    // Flush with stall toggling every other cycle
    flush_req = 1;
    flush_writes = 0;
    cycle();
    flush_req = 0;
    for (int k = 0; k < 100 && m_flush; k++) begin
      btb_stall = k[0];
      cycle();
    end
    btb_stall = 0;
    cycle();
    check("flush_write_count_stall", 32'(flush_writes), 32'(NUM_ENTRIES));

    // Reset in the middle of a walk
    flush_req = 1;
    cycle();
    flush_req = 0;
    for (int k = 0; k < 100 && m_flush && m_walk != 7; k++) cycle();
    rst = 1;
    cycle();
    rst = 0;
    check("no_done_after_rst", 32'(flush_done), 32'h0);
    check("idle_after_rst", 32'(flush_busy), 32'h0);
    repeat (2) cycle();

    // Same PC posted twice under stall
    btb_stall = 1; res0_valid = 1; res0_pc = 32'h40; res0_taken = 1; res0_target = 32'h800;
    cycle();
    res0_taken = 0; res0_target = 32'h900;
    cycle();
    res0_valid = 0;
`ifdef BTB_UPD_COALESCE_EN
    check("same_pc_count", 32'(queue_count), 32'd1);
`else
    check("same_pc_count", 32'(queue_count), 32'd2);
`endif
    btb_stall = 0;
    repeat (3) cycle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 199) == 0);
      flush_req  = ($urandom_range(0, 29) == 0);
      btb_stall  = ($urandom_range(0, 2) == 0);
      res0_valid = 1'($urandom_range(0, 1));
      res1_valid = 1'($urandom_range(0, 1));
      res0_pc    = 32'($urandom_range(0, 7)) * 4;
      res1_pc    = 32'($urandom_range(0, 7)) * 4;
      res0_taken = 1'($urandom_range(0, 1));
      res1_taken = 1'($urandom_range(0, 1));
      res0_target = $urandom;
      res1_target = $urandom;
      cycle();
    end
    idle_inputs();
    repeat (25) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
